bip_control_unit: RTL and testbench
===================================

Name: bip_control_unit

Overview:
- Instruction-fetch and decode stage of the BIP1 processor. Sits directly upstream of the datapath.
- Holds the program counter (PC) and addresses program memory.
- Decodes each 16-bit instruction into datapath controls (selA, selB, WrAcc, Op, operand) and data-memory strobes.
- Runs an IDLE/RUN/HALT state machine and a saturating cycle counter for the debug path.

Parameters:
- NB_INSTR, 16, instruction width.
- NB_OPCODE, 5, opcode field width, bits [15:11].
- NB_OPERAND, 11, operand field width, bits [10:0]. Also sets PC and data-address width.
- NB_CYCLES, 16, width of the cycle counter.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle pulse that starts execution from IDLE.
- i_instruction  in  NB_INSTR  program-memory word at o_pc. Combinational read, same cycle.
- o_pc  out  NB_OPERAND  program-memory address.
- o_selA  out  2  accumulator source: 00 data mem, 01 operand, 10 ALU.
- o_selB  out  1  ALU B source: 0 data mem, 1 operand.
- o_WrAcc  out  1  accumulator write enable.
- o_Op  out  1  ALU op: 0 add, 1 sub.
- o_WrRam  out  1  data-memory write strobe.
- o_RdRam  out  1  data-memory read strobe.
- o_Operand  out  NB_OPERAND  instruction operand field, passed through.
- o_halt  out  1  high while in HALT.
- o_cycles  out  NB_CYCLES  clocks spent in RUN.

Behaviour:
- Reset (async, active-high) forces: state IDLE, PC 0, o_cycles 0, o_halt 0. All control outputs are 0 while reset is asserted and while not in RUN.
- States:
  - IDLE: wait for i_start, then go to RUN on the next edge. PC stays 0.
  - RUN: one instruction per clock. Controls are combinational from i_instruction. PC advances on the edge that ends the cycle.
  - HALT: terminal. PC and o_cycles are frozen, o_halt=1. i_start is ignored. Only reset leaves HALT.
- Decode table (opcode -> selA, selB, WrAcc, Op, WrRam, RdRam):
  - HLT 00000 -> 00,0,0,0,0,0. Next state HALT; PC not incremented.
  - STO 00001 -> 00,0,0,0,1,0.
  - LD 00010 -> 00,0,1,0,0,1.
  - LDI 00011 -> 01,0,1,0,0,0.
  - ADD 00100 -> 10,0,1,0,0,1.
  - ADDI 00101 -> 10,1,1,0,0,0.
  - SUB 00110 -> 10,0,1,1,0,1.
  - SUBI 00111 -> 10,1,1,1,0,0.
  - Any other opcode: NOP (all controls 0), PC increments.
- o_Operand = i_instruction[10:0] in every state. Sign-extension is the datapath's job.
- PC: increments by 1 modulo 2^NB_OPERAND; 2047 wraps to 0 with no flag.
- o_cycles: increments on every edge spent in RUN, including the HLT cycle. Saturates at all-ones.
- i_start while in RUN has no effect.
- Reset mid-RUN aborts immediately; any strobe in flight is dropped combinationally.

Decomposition:
- Package bip_pkg holds:
  - opcode localparams (OP_HLT..OP_SUBI);
  - selA encodings (SELA_MEM, SELA_OPR, SELA_ALU);
  - state encodings (ST_IDLE, ST_RUN, ST_HALT);
  - field widths.
- One sub-module, bip_instr_decoder: purely combinational, opcode -> control bundle plus is_halt.
- The top module keeps the FSM, PC and cycle counter.

Test Plan:
- Reset then i_start pulse, ROM = {LDI 5, ADDI 3, STO 7, HLT} -> o_pc 0,1,2,3 in successive cycles. Controls at pc=2: WrRam=1, o_Operand=7. o_halt=1 from the cycle after pc=3, o_cycles=4, o_pc frozen at 3.
- All eight opcodes, one per cycle -> control bundle matches the decode table exactly. Opcode 11111 -> all controls 0 and PC increments.
- ROM all NOP, run 2050 cycles -> o_pc wraps 2047->0 and keeps incrementing.
- i_reset asserted mid-RUN at pc=10 -> outputs 0 asynchronously, before the next edge. After release: IDLE, pc=0, o_cycles=0, and no advance until i_start.
- i_start pulsed in HALT and again in RUN -> no state change, no PC jump.
- NB_CYCLES=4, program of 20 NOPs -> o_cycles saturates at 15.

Source files
------------

// File: rtl/bip_control_unit_pkg.sv
// bip_pkg: shared opcodes, encodings, widths and control bundle for the BIP1 fetch/decode stage
package bip_pkg;
  localparam int INSTR_W = 16;
  localparam int OPCODE_W = 5;
  localparam int OPERAND_W = 11;
  localparam int CYCLES_W = 16;
  localparam logic [OPCODE_W-1:0] OP_HLT = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_STO = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_LD = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDI = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ADD = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SUB = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'b00111;
  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_OPR = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;
  typedef struct packed {
    logic [1:0] sel_a;
    logic sel_b;
    logic wr_acc;
    logic op;
    logic wr_ram;
    logic rd_ram;
  } ctrl_t;
endpackage

// File: rtl/bip_control_unit_if.sv
// bip_control_unit_if: program-memory and datapath-control bundle of the BIP1 control unit
interface bip_control_unit_if #(
  parameter int NB_INSTR = 16,
  parameter int NB_OPERAND = 11,
  parameter int NB_CYCLES = 16
);
  logic i_start;
  logic [NB_INSTR-1:0] i_instruction;
  logic [NB_OPERAND-1:0] o_pc;
  logic [1:0] o_selA;
  logic o_selB;
  logic o_WrAcc;
  logic o_Op;
  logic o_WrRam;
  logic o_RdRam;
  logic [NB_OPERAND-1:0] o_Operand;
  logic o_halt;
  logic [NB_CYCLES-1:0] o_cycles;
  modport master (
    input i_start, i_instruction,
    output o_pc, o_selA, o_selB, o_WrAcc, o_Op, o_WrRam, o_RdRam, o_Operand, o_halt, o_cycles
  );
  modport slave (
    output i_start, i_instruction,
    input o_pc, o_selA, o_selB, o_WrAcc, o_Op, o_WrRam, o_RdRam, o_Operand, o_halt, o_cycles
  );
endinterface

// File: rtl/bip_control_unit_instr_decoder.sv
// bip_instr_decoder: combinational opcode to datapath control bundle, flags HLT
module bip_instr_decoder import bip_pkg::*; (
  input logic [OPCODE_W-1:0] opcode,
  output ctrl_t ctrl,
  output logic is_halt
);
  // decode table; unknown opcodes fall through as NOP
  always_comb begin
    ctrl = '0;
    is_halt = 1'b0;
    case (opcode)
      OP_HLT: is_halt = 1'b1;
      OP_STO: ctrl = '{SELA_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      OP_LD: ctrl = '{SELA_MEM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      OP_LDI: ctrl = '{SELA_OPR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_ADD: ctrl = '{SELA_ALU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      OP_ADDI: ctrl = '{SELA_ALU, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      OP_SUB: ctrl = '{SELA_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      OP_SUBI: ctrl = '{SELA_ALU, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/bip_control_unit.sv
// bip_control_unit: BIP1 fetch/decode stage with PC, IDLE/RUN/HALT FSM and saturating cycle counter
module bip_control_unit import bip_pkg::*; #(
  parameter int NB_INSTR = INSTR_W,
  parameter int NB_OPCODE = OPCODE_W,
  parameter int NB_OPERAND = OPERAND_W,
  parameter int NB_CYCLES = CYCLES_W
) (
  input logic i_clock,
  input logic i_reset,
  bip_control_unit_if.master bus
);
  state_t state;
  ctrl_t dec;
  logic is_halt;
  logic run;
  bip_instr_decoder u_dec (
    .opcode(bus.i_instruction[NB_INSTR-1 -: NB_OPCODE]),
    .ctrl(dec),
    .is_halt(is_halt)
  );
  assign run = state == ST_RUN;
  assign bus.o_selA = run ? dec.sel_a : SELA_MEM;
  assign bus.o_selB = run & dec.sel_b;
  assign bus.o_WrAcc = run & dec.wr_acc;
  assign bus.o_Op = run & dec.op;
  assign bus.o_WrRam = run & dec.wr_ram;
  assign bus.o_RdRam = run & dec.rd_ram;
  assign bus.o_Operand = bus.i_instruction[NB_OPERAND-1:0];
  // FSM with PC, halt flag and cycle counter; HALT freezes everything until reset
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state <= ST_IDLE;
      bus.o_pc <= '0;
      bus.o_cycles <= '0;
      bus.o_halt <= 1'b0;
    end else
      case (state)
        ST_IDLE: state <= bus.i_start ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          state <= is_halt ? ST_HALT : ST_RUN;
          bus.o_halt <= is_halt;
          bus.o_pc <= is_halt ? bus.o_pc : bus.o_pc + 1'b1;
          bus.o_cycles <= &bus.o_cycles ? bus.o_cycles : bus.o_cycles + 1'b1;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: scoreboard bench for the BIP1 control unit with directed programs
module tb_bip_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bip_control_unit_if #(.NB_CYCLES(16)) bus();
  bip_control_unit_if #(.NB_CYCLES(4)) bus4();
  bip_control_unit dut (.i_clock(clk), .i_reset(rst), .bus(bus));
  bip_control_unit #(.NB_CYCLES(4)) dut4 (.i_clock(clk), .i_reset(rst), .bus(bus4));
  logic [15:0] rom [2048];
  logic [15:0] rom4 [2048];
  assign bus.i_instruction = rom[bus.o_pc];
  assign bus4.i_instruction = rom4[bus4.o_pc];
  typedef struct {
    bit which;
    logic [10:0] pc;
    logic [6:0] ctrl;
    logic [10:0] opr;
    logic halt;
    logic [15:0] cyc;
    string name;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  event smp;
  localparam logic [6:0] C_NONE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] C_STO = 7'b00_0_0_0_1_0;
  localparam logic [6:0] C_LD = 7'b00_0_1_0_0_1;
  localparam logic [6:0] C_LDI = 7'b01_0_1_0_0_0;
  localparam logic [6:0] C_ADD = 7'b10_0_1_0_0_1;
  localparam logic [6:0] C_ADDI = 7'b10_1_1_0_0_0;
  localparam logic [6:0] C_SUB = 7'b10_0_1_1_0_1;
  localparam logic [6:0] C_SUBI = 7'b10_1_1_1_0_0;
  logic [6:0] tab [8];
  initial begin : mon
    exp_t e;
    logic [45:0] act;
    logic [45:0] want;
    forever begin
      @(negedge clk or smp);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = e.which ?
          {bus4.o_pc, bus4.o_selA, bus4.o_selB, bus4.o_WrAcc, bus4.o_Op, bus4.o_WrRam, bus4.o_RdRam,
           bus4.o_Operand, bus4.o_halt, 12'd0, bus4.o_cycles} :
          {bus.o_pc, bus.o_selA, bus.o_selB, bus.o_WrAcc, bus.o_Op, bus.o_WrRam, bus.o_RdRam,
           bus.o_Operand, bus.o_halt, bus.o_cycles};
        want = {e.pc, e.ctrl, e.opr, e.halt, e.cyc};
        checks++;
        if (act !== want) begin
          failures++;
          $display("FAIL %s t=%0t got pc=%0d ctrl=%b opr=%0d halt=%b cyc=%0d expected pc=%0d ctrl=%b opr=%0d halt=%b cyc=%0d",
                   e.name, $time, act[45:35], act[34:28], act[27:17], act[16], act[15:0],
                   e.pc, e.ctrl, e.opr, e.halt, e.cyc);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input bit w, input logic [10:0] pc, input logic [6:0] c, input logic [10:0] opr,
                     input logic h, input logic [15:0] cy, input string n);
    q.push_back('{w, pc, c, opr, h, cy, n});
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask
  task automatic fill_nop;
    for (int i = 0; i < 2048; i++) begin
      rom[i] = {5'b11111, 11'(i)};
      rom4[i] = {5'b11111, 11'(i)};
    end
  endtask
  initial begin
    tab = '{C_NONE, C_STO, C_LD, C_LDI, C_ADD, C_ADDI, C_SUB, C_SUBI};
    bus.i_start = 1'b0;
    bus4.i_start = 1'b0;
    fill_nop;
    rom[0] = {5'b00011, 11'd5};
    rom[1] = {5'b00101, 11'd3};
    rom[2] = {5'b00001, 11'd7};
    rom[3] = {5'b00000, 11'd0};
    tick;
    tick;
    chk(0, 0, C_NONE, 5, 0, 0, "reset_held");
    tick;
    rst = 1'b0;
    chk(0, 0, C_NONE, 5, 0, 0, "idle");
    tick;
    bus.i_start = 1'b1;
    chk(0, 0, C_NONE, 5, 0, 0, "idle_start");
    tick;
    bus.i_start = 1'b0;
    chk(0, 0, C_LDI, 5, 0, 0, "prog_ldi");
    tick;
    chk(0, 1, C_ADDI, 3, 0, 1, "prog_addi");
    tick;
    chk(0, 2, C_STO, 7, 0, 2, "prog_sto");
    tick;
    chk(0, 3, C_NONE, 0, 0, 3, "prog_hlt");
    tick;
    chk(0, 3, C_NONE, 0, 1, 4, "halted");
    bus.i_start = 1'b1;
    tick;
    bus.i_start = 1'b0;
    chk(0, 3, C_NONE, 0, 1, 4, "halt_start");
    tick;
    chk(0, 3, C_NONE, 0, 1, 4, "halt_hold");
    tick;
    do_reset;
    for (int k = 0; k < 7; k++) rom[k] = {5'(k + 1), 11'(100 + k)};
    rom[7] = {5'b11111, 11'd107};
    rom[8] = {5'b00000, 11'd108};
    bus.i_start = 1'b1;
    tick;
    bus.i_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) bus.i_start = 1'b1;
      if (k == 4) bus.i_start = 1'b0;
      chk(0, 11'(k), k < 7 ? tab[k + 1] : C_NONE, 11'(100 + k), 0, 16'(k), $sformatf("decode_%0d", k));
      tick;
    end
    chk(0, 8, C_NONE, 108, 1, 9, "decode_halt");
    tick;
    do_reset;
    fill_nop;
    bus.i_start = 1'b1;
    tick;
    bus.i_start = 1'b0;
    for (int k = 0; k < 2050; k++) begin
      chk(0, 11'(k), C_NONE, 11'(k), 0, 16'(k), "wrap");
      tick;
    end
    chk(0, 2, C_NONE, 2, 0, 2050, "wrap_end");
    tick;
    do_reset;
    rom[10] = {5'b00001, 11'd10};
    bus.i_start = 1'b1;
    tick;
    bus.i_start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk(0, 11'(k), k == 10 ? C_STO : C_NONE, 11'(k), 0, 16'(k), "pre_abort");
      if (k < 10) tick;
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk(0, 0, C_NONE, 0, 0, 0, "async_abort");
    ->smp;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk(0, 0, C_NONE, 0, 0, 0, "post_abort_idle");
    end
    tick;
    bus4.i_start = 1'b1;
    tick;
    bus4.i_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk(1, 11'(k), C_NONE, 11'(k), 0, k > 15 ? 16'd15 : 16'(k), "sat");
      tick;
    end
    chk(1, 20, C_NONE, 20, 0, 15, "sat_end");
    tick;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
